prog_loader: RTL and testbench

Program-memory front end for the 8-bit microprocessor, directly upstream of its `INST` input. It accepts a length-prefixed program image over a byte-wide valid/ready port and writes it into a 256x8 program memory. It zero-fills the unused addresses, then releases the CPU from clear. Once running, it serves `INST = mem[PC]` to the core.

---
 rtl/micro_pkg.sv | 17 +
 rtl/prog_mem.sv | 23 ++
 rtl/prog_loader.sv | 100 ++++++++++
 tb/tb_prog_loader.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/micro_pkg.sv
// Shared types and sizing for the microprocessor front end.
// The program loader's state encoding lives here so the core and the loader agree on it.
package micro_pkg;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam logic [7:0] FILL_VALUE = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    FILL,
    RUN
  } loader_state_t;

endpackage

// File: rtl/prog_mem.sv
// Program memory, 2**AW x DW.
// Synchronous write port, asynchronous read port; contents are never reset.
module prog_mem #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// Length-prefixed program image loader feeding the core's INST port.
// It writes the image, pads the rest of memory, then releases the core from clear.
module prog_loader
  import micro_pkg::*;
#(
  parameter int          DW         = micro_pkg::DW,
  parameter int          AW         = micro_pkg::AW,
  parameter logic [DW-1:0] FILL_VALUE = DW'(micro_pkg::FILL_VALUE)
) (
  input  logic          clk,
  input  logic          CLB,
  input  logic          load_start,
  input  logic [DW-1:0] load_data,
  input  logic          load_valid,
  output logic          load_ready,
  output logic          load_done,
  output logic          busy,
  input  logic [AW-1:0] PC,
  output logic [DW-1:0] INST,
  output logic          cpu_CLB
);

  loader_state_t state, state_n;
  logic [AW-1:0] wp, wp_n;
  logic [AW:0]   remain, remain_n;
  logic          done_n;
  logic          xfer, we;
  logic [DW-1:0] wdata, rdata;

  assign load_ready = (state == HDR) || (state == LOAD);
  assign busy       = load_ready || (state == FILL);
  assign cpu_CLB    = (state == RUN);
  assign INST       = (state == RUN) ? rdata : '0;
  assign xfer       = load_valid && load_ready;

  always_comb begin
    state_n  = state;
    wp_n     = wp;
    remain_n = remain;
    done_n   = 1'b0;
    we       = 1'b0;
    wdata    = load_data;
    case (state)
      IDLE, RUN: if (load_start) state_n = HDR;
      HDR: if (xfer) begin
        // a zero header encodes a full-depth image
        wp_n     = '0;
        remain_n = (load_data == '0) ? (AW+1)'(2**AW) : (AW+1)'(load_data);
        state_n  = LOAD;
      end
      LOAD: if (xfer) begin
        we       = 1'b1;
        wp_n     = wp + AW'(1);
        remain_n = remain - (AW+1)'(1);
        if (remain == (AW+1)'(1)) begin
          if (wp_n == '0) begin
            state_n = RUN;
            done_n  = 1'b1;
          end else begin
            state_n = FILL;
          end
        end
      end
      FILL: begin
        we    = 1'b1;
        wdata = FILL_VALUE;
        wp_n  = wp + AW'(1);
        if (wp == {AW{1'b1}}) begin
          state_n = RUN;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      state     <= IDLE;
      wp        <= '0;
      remain    <= '0;
      load_done <= 1'b0;
    end else begin
      state     <= state_n;
      wp        <= wp_n;
      remain    <= remain_n;
      load_done <= done_n;
    end
  end

  prog_mem #(.DW(DW), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wp),
    .wdata (wdata),
    .raddr (PC),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader against an array model of the loaded image.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       CLB, load_start, load_valid;
  logic [7:0] load_data, PC, INST;
  logic       load_ready, load_done, busy, cpu_CLB;

  logic [7:0] img [256];
  logic [7:0] ref_mem [256];
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk        (clk),
    .CLB        (CLB),
    .load_start (load_start),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_done  (load_done),
    .busy       (busy),
    .PC         (PC),
    .INST       (INST),
    .cpu_CLB    (cpu_CLB)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall, input logic pulse);
    int s = 0;
    int t = 0;
    while (stall > 0 && s < 8 && int'($urandom_range(99)) < stall) begin
      load_valid = 1'b0;
      tick();
      s++;
    end
    load_data  = b;
    load_valid = 1'b1;
    load_start = pulse;
    while (!load_ready && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) chk("ready_timeout", 0, 1);
    tick();
    load_valid = 1'b0;
    load_start = 1'b0;
  endtask

  task automatic sweep(input string tag);
    for (int pc = 0; pc < 256; pc++) begin
      PC = 8'(pc);
      #1;
      chk(tag, INST, ref_mem[pc]);
    end
  endtask

  task automatic do_load(input int L, input int stall, input bit mid);
    int k;
    logic [31:0] hl;
    hl = L;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("clb_drop", cpu_CLB, 0);
    chk("busy_hdr", busy, 1);
    send_byte(hl[7:0], stall, 1'b0);
    for (int i = 0; i < L; i++) send_byte(img[i], stall, mid && i == 1);
    k = 0;
    while (!load_done && k < 300) begin
      if (L < 256 && k == 0) chk("inst_fill", INST, 0);
      load_start = mid && k == 0;
      tick();
      k++;
    end
    load_start = 1'b0;
    chk("fill_cycles", k, 256 - L);
    chk("clb_run", cpu_CLB, 1);
    chk("ready_run", load_ready, 0);
    chk("busy_run", busy, 0);
    for (int i = 0; i < 256; i++) ref_mem[i] = (i < L) ? img[i] : 8'h00;
    tick();
    chk("done_pulse", load_done, 0);
    chk("clb_hold", cpu_CLB, 1);
    sweep("inst_run");
  endtask

  initial begin
    CLB = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_data = '0; PC = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_clb", cpu_CLB, 0);
    CLB = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_clb", cpu_CLB, 0);
      chk("idle_inst", INST, 0);
      chk("idle_ready", load_ready, 0);
      chk("idle_done", load_done, 0);
    end

    // short image
    img[0] = 8'hA1; img[1] = 8'hB2; img[2] = 8'hC3;
    do_load(3, 0, 1'b0);

    // full image with stalls
    for (int i = 0; i < 256; i++) img[i] = 8'(i) ^ 8'h5A;
    do_load(256, 50, 1'b0);

    // reload from RUN: residue of the full image must be gone
    img[0] = 8'h7E;
    do_load(1, 0, 1'b0);

    // ignored start pulses during LOAD and FILL
    for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
    do_load(40, 20, 1'b1);

    // reset mid-load
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    send_byte(8'd5, 0, 1'b0);
    send_byte(8'h11, 0, 1'b0);
    send_byte(8'h22, 0, 1'b0);
    CLB = 1'b0;
    #2;
    chk("mid_rst_clb", cpu_CLB, 0);
    chk("mid_rst_ready", load_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_inst", INST, 0);
    tick();
    CLB = 1'b1;
    tick();
    chk("post_rst_clb", cpu_CLB, 0);
    for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
    do_load(256, 10, 1'b0);

    // random images
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
      do_load(int'($urandom_range(256, 1)), int'($urandom_range(60)), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
